// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: folds E0/F0/E1 prefixes into {ext, brk, code} events,
// tracks modifier/caps-lock state and buffers events in a first-word fall-through FIFO.
module ps2_scan_decoder #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [9:0] evt_data,
  output logic       evt_valid,
  input  logic       evt_rd,
  output logic [2:0] mods,
  output logic       caps,
  output logic       ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    pcnt_q, pcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          push;
  logic [9:0]    push_ev;

  logic shift_q, shift_d, ctrl_q, ctrl_d, alt_q, alt_d;
  logic caps_q, caps_d, held58_q, held58_d;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          pop, full, wr_en;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    push    = 1'b0;
    push_ev = '0;
    if (rx_valid && rx_err) begin
      state_d = S_IDLE;
      pcnt_d  = '0;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          case (rx_data)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              state_d = S_PAUSE;
              pcnt_d  = '0;
            end
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: ;
            default: begin
              push    = 1'b1;
              push_ev = {2'b00, rx_data};
            end
          endcase
        end
        S_EXT: begin
          if (rx_data == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            push    = 1'b1;
            push_ev = {2'b10, rx_data};
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          push    = 1'b1;
          push_ev = {2'b01, rx_data};
          state_d = S_IDLE;
        end
        S_EXT_BRK: begin
          push    = 1'b1;
          push_ev = {2'b11, rx_data};
          state_d = S_IDLE;
        end
        S_PAUSE: begin
          // E1 plus seven payload bytes collapse into a single pause event
          if (pcnt_q == 3'd6) begin
            push    = 1'b1;
            push_ev = {2'b00, 8'hE1};
            state_d = S_IDLE;
            pcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tcnt_q == TLAST) begin
      state_d = S_IDLE;
      pcnt_d  = '0;
    end
  end

  always_comb begin
    if (rx_valid || state_q == S_IDLE || tcnt_q == TLAST) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_comb begin
    shift_d  = shift_q;
    ctrl_d   = ctrl_q;
    alt_d    = alt_q;
    caps_d   = caps_q;
    held58_d = held58_q;
    if (push) begin
      if (!push_ev[9] && (push_ev[7:0] == 8'h12 || push_ev[7:0] == 8'h59)) shift_d = !push_ev[8];
      if (push_ev[7:0] == 8'h14) ctrl_d = !push_ev[8];
      if (push_ev[7:0] == 8'h11) alt_d = !push_ev[8];
      // Typematic repeats of 0x58 arrive as makes while held; only the first toggles
      if (!push_ev[9] && push_ev[7:0] == 8'h58) begin
        if (push_ev[8]) begin
          held58_d = 1'b0;
        end else begin
          if (!held58_q) caps_d = !caps_q;
          held58_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      pcnt_q   <= '0;
      tcnt_q   <= '0;
      shift_q  <= 1'b0;
      ctrl_q   <= 1'b0;
      alt_q    <= 1'b0;
      caps_q   <= 1'b0;
      held58_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      tcnt_q   <= tcnt_d;
      shift_q  <= shift_d;
      ctrl_q   <= ctrl_d;
      alt_q    <= alt_d;
      caps_q   <= caps_d;
      held58_q <= held58_d;
    end
  end

  assign pop   = evt_rd && (cnt_q != '0);
  assign full  = (cnt_q == FULL_CNT);
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= push_ev;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (wr_en && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!wr_en && pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign evt_data  = mem_q[rd_q];
  assign evt_valid = (cnt_q != '0);
  assign mods      = {alt_q, ctrl_q, shift_q};
  assign caps      = caps_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: directed scenarios plus randomized byte
// streams scored against a prefix/queue level reference model.
module tb_ps2_scan_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 40;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic       evt_rd = 1'b0;
  logic [9:0] evt_data;
  logic       evt_valid;
  logic [2:0] mods;
  logic       caps;
  logic       ovf;

  always #5 clk = ~clk;

  ps2_scan_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .arst_n(arst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .evt_data(evt_data), .evt_valid(evt_valid), .evt_rd(evt_rd),
    .mods(mods), .caps(caps), .ovf(ovf)
  );

  int errs = 0;
  int checks = 0;

  // Reference model: pending prefix flags, pause bytes still expected, event queue
  logic [9:0] q[$];
  bit         m_ext, m_brk;
  int         m_pause, m_gap;
  logic [2:0] m_mods;
  logic       m_caps, m_held, m_ovf;

  task automatic m_clear();
    q.delete();
    m_ext = 0; m_brk = 0; m_pause = 0; m_gap = 0;
    m_mods = '0; m_caps = 0; m_held = 0; m_ovf = 0;
  endtask

  task automatic m_byte(input logic [7:0] b, input logic err, input logic rd);
    logic [9:0] ev;
    bit hit;
    hit = 0;
    ev  = '0;
    if (m_gap >= int'(TO)) begin m_ext = 0; m_brk = 0; m_pause = 0; end
    m_gap = 0;
    if (rd && q.size() > 0) void'(q.pop_front());
    if (err) begin
      m_ext = 0; m_brk = 0; m_pause = 0;
    end else if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) begin ev = {2'b00, 8'hE1}; hit = 1; end
    end else if (b == 8'hF0 && !m_brk) begin
      m_brk = 1;
    end else if (b == 8'hE0 && !m_ext && !m_brk) begin
      m_ext = 1;
    end else if (b == 8'hE1 && !m_ext && !m_brk) begin
      m_pause = 7;
    end else if (!m_ext && !m_brk && (b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
      hit = 0;
    end else begin
      ev = {m_ext, m_brk, b}; hit = 1; m_ext = 0; m_brk = 0;
    end
    if (hit) begin
      if (!ev[9] && (ev[7:0] == 8'h12 || ev[7:0] == 8'h59)) m_mods[0] = !ev[8];
      if (ev[7:0] == 8'h14) m_mods[1] = !ev[8];
      if (ev[7:0] == 8'h11) m_mods[2] = !ev[8];
      if (!ev[9] && ev[7:0] == 8'h58) begin
        if (ev[8]) m_held = 0;
        else begin
          if (!m_held) m_caps = !m_caps;
          m_held = 1;
        end
      end
      if (q.size() < int'(DEPTH)) q.push_back(ev);
      else m_ovf = 1;
    end
  endtask

  // All stimulus tasks start and end just after a falling edge
  task automatic send(input logic [7:0] b, input logic err = 1'b0, input logic rd = 1'b0);
    rx_data = b; rx_valid = 1'b1; rx_err = err; evt_rd = rd;
    @(negedge clk);
    rx_valid = 1'b0; rx_err = 1'b0; evt_rd = 1'b0;
    m_byte(b, err, rd);
  endtask

  task automatic do_pop();
    evt_rd = 1'b1;
    @(negedge clk);
    evt_rd = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    m_gap++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    m_gap += n;
  endtask

  task automatic hard_reset();
    arst_n = 1'b0;
    #1;
    @(negedge clk);
    arst_n = 1'b1;
    m_clear();
  endtask

  task automatic test_reset();
    #2 arst_n = 1'b0;
    #1;
    checks++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
    checks++; if (evt_data !== 10'h000) begin errs++; $display("FAIL rst_data: got %h want 000", evt_data); end
    checks++; if (mods !== 3'b000) begin errs++; $display("FAIL rst_mods: got %b want 000", mods); end
    checks++; if (caps !== 1'b0) begin errs++; $display("FAIL rst_caps: got %b want 0", caps); end
    checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    @(negedge clk);
    arst_n = 1'b1;
    m_clear();
  endtask

  task automatic test_make_break();
    hard_reset();
    checks++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL mb_pre_valid: got %b want 0", evt_valid); end
    send(8'h1C);
    checks++; if (evt_valid !== 1'b1) begin errs++; $display("FAIL mb_make_latency: got %b want 1", evt_valid); end
    checks++; if (evt_data !== 10'h01C) begin errs++; $display("FAIL mb_make_data: got %h want 01c", evt_data); end
    do_pop();
    send(8'hF0);
    checks++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL mb_prefix_noevt: got %b want 0", evt_valid); end
    send(8'h1C);
    checks++; if (evt_valid !== 1'b1) begin errs++; $display("FAIL mb_brk_latency: got %b want 1", evt_valid); end
    checks++; if (evt_data !== 10'h11C) begin errs++; $display("FAIL mb_brk_data: got %h want 11c", evt_data); end
    do_pop();
    checks++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL mb_empty: got %b want 0", evt_valid); end
  endtask

  task automatic test_ext();
    hard_reset();
    send(8'hE0); send(8'h75);
    checks++; if (evt_data !== 10'h275 || evt_valid !== 1'b1) begin errs++; $display("FAIL ext_make: got %b/%h want 1/275", evt_valid, evt_data); end
    do_pop();
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++; if (evt_data !== 10'h375 || evt_valid !== 1'b1) begin errs++; $display("FAIL ext_brk: got %b/%h want 1/375", evt_valid, evt_data); end
    do_pop();
    send(8'hAA); send(8'hFA); send(8'h00); send(8'hFE); send(8'hFF);
    checks++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL ext_dropped: got %b want 0", evt_valid); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    bit early;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    early = 0;
    hard_reset();
    for (int i = 0; i < 8; i++) begin
      send(seq[i]);
      if (i < 7 && evt_valid) early = 1;
    end
    checks++; if (early !== 1'b0) begin errs++; $display("FAIL pause_early: got %b want 0", early); end
    checks++; if (evt_data !== 10'h0E1 || evt_valid !== 1'b1) begin errs++; $display("FAIL pause_evt: got %b/%h want 1/0e1", evt_valid, evt_data); end
    checks++; if (mods !== 3'b000) begin errs++; $display("FAIL pause_mods: got %b want 000", mods); end
    do_pop();
    checks++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL pause_once: got %b want 0", evt_valid); end
    send(8'h1C);
    checks++; if (evt_data !== 10'h01C) begin errs++; $display("FAIL pause_idle: got %h want 01c", evt_data); end
    do_pop();
  endtask

  task automatic test_mods();
    hard_reset();
    send(8'h12);
    checks++; if (mods !== 3'b001) begin errs++; $display("FAIL mod_shift_make: got %b want 001", mods); end
    send(8'h58);
    checks++; if (caps !== 1'b1) begin errs++; $display("FAIL caps_toggle: got %b want 1", caps); end
    send(8'h58);
    checks++; if (caps !== 1'b1) begin errs++; $display("FAIL caps_repeat: got %b want 1", caps); end
    send(8'hF0); send(8'h58); send(8'hF0); send(8'h12);
    checks++; if (mods !== 3'b000) begin errs++; $display("FAIL mod_shift_brk: got %b want 000", mods); end
    checks++; if (caps !== 1'b1) begin errs++; $display("FAIL caps_hold: got %b want 1", caps); end
    checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL mod_ovf: got %b want 1", ovf); end
    hard_reset();
    send(8'h58); send(8'hF0); send(8'h58); send(8'h58);
    checks++; if (caps !== 1'b0) begin errs++; $display("FAIL caps_retoggle: got %b want 0", caps); end
    send(8'hE0); send(8'h14);
    checks++; if (mods !== 3'b010) begin errs++; $display("FAIL mod_ctrl_ext: got %b want 010", mods); end
    send(8'h11);
    checks++; if (mods !== 3'b110) begin errs++; $display("FAIL mod_alt: got %b want 110", mods); end
    send(8'hE0); send(8'hF0); send(8'h11); send(8'hF0); send(8'h14);
    checks++; if (mods !== 3'b000) begin errs++; $display("FAIL mod_release: got %b want 000", mods); end
    send(8'hE0); send(8'h12);
    checks++; if (mods !== 3'b000) begin errs++; $display("FAIL mod_ext12: got %b want 000", mods); end
    send(8'h59);
    checks++; if (mods !== 3'b001) begin errs++; $display("FAIL mod_rshift: got %b want 001", mods); end
    send(8'hF0); send(8'h59);
    checks++; if (mods !== 3'b000) begin errs++; $display("FAIL mod_rshift_brk: got %b want 000", mods); end
  endtask

  task automatic test_overflow();
    logic [7:0] mk [5];
    logic [7:0] exp4 [4];
    mk   = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    exp4 = '{8'h1D, 8'h24, 8'h2D, 8'h2C};
    hard_reset();
    for (int i = 0; i < 4; i++) send(mk[i]);
    checks++; if (ovf !== 1'b0 || evt_data !== 10'h015) begin errs++; $display("FAIL ovf_fill: got %b/%h want 0/015", ovf, evt_data); end
    send(mk[4], 1'b0, 1'b1);
    checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL ovf_pushpop_full: got %b want 0", ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_data !== {2'b00, exp4[i]}) begin errs++; $display("FAIL ovf_pp_order%0d: got %h want %h", i, evt_data, {2'b00, exp4[i]}); end
      do_pop();
    end
    checks++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL ovf_pp_empty: got %b want 0", evt_valid); end
    for (int i = 0; i < 5; i++) send(mk[i]);
    checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b want 1", ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_data !== {2'b00, mk[i]}) begin errs++; $display("FAIL ovf_order%0d: got %h want %h", i, evt_data, {2'b00, mk[i]}); end
      do_pop();
    end
    checks++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL ovf_dropped: got %b want 0", evt_valid); end
    send(8'h1C, 1'b0, 1'b1);
    checks++; if (evt_valid !== 1'b1 || evt_data !== 10'h01C) begin errs++; $display("FAIL pushpop_empty: got %b/%h want 1/01c", evt_valid, evt_data); end
    do_pop();
  endtask

  task automatic test_timeout_err();
    hard_reset();
    send(8'hE0); idle(TO + 1); send(8'h1C);
    checks++; if (evt_data !== 10'h01C || evt_valid !== 1'b1) begin errs++; $display("FAIL to_abandon: got %b/%h want 1/01c", evt_valid, evt_data); end
    do_pop();
    send(8'hE0); idle(TO - 3); send(8'h75);
    checks++; if (evt_data !== 10'h275) begin errs++; $display("FAIL to_within: got %h want 275", evt_data); end
    do_pop();
    send(8'hE1); send(8'h14); idle(TO + 1); send(8'h1C);
    checks++; if (evt_data !== 10'h01C || evt_valid !== 1'b1) begin errs++; $display("FAIL to_pause: got %b/%h want 1/01c", evt_valid, evt_data); end
    do_pop();
    send(8'hE0); send(8'h1C, 1'b1);
    checks++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL err_noevt: got %b want 0", evt_valid); end
    send(8'h1C);
    checks++; if (evt_data !== 10'h01C) begin errs++; $display("FAIL err_idle: got %h want 01c", evt_data); end
    do_pop();
    send(8'hE1); send(8'h14); send(8'h77, 1'b1); send(8'h1C);
    checks++; if (evt_data !== 10'h01C || evt_valid !== 1'b1) begin errs++; $display("FAIL err_pause: got %b/%h want 1/01c", evt_valid, evt_data); end
    do_pop();
    send(8'h12); send(8'h58); send(8'hF0);
    arst_n = 1'b0;
    #1;
    checks++; if (evt_valid !== 1'b0 || evt_data !== 10'h000) begin errs++; $display("FAIL arst_fifo: got %b/%h want 0/000", evt_valid, evt_data); end
    checks++; if (mods !== 3'b000 || caps !== 1'b0 || ovf !== 1'b0) begin errs++; $display("FAIL arst_state: got %b/%b/%b want 000/0/0", mods, caps, ovf); end
    @(negedge clk);
    arst_n = 1'b1;
    m_clear();
    send(8'h1C);
    checks++; if (evt_data !== 10'h01C) begin errs++; $display("FAIL arst_prefix: got %h want 01c", evt_data); end
    do_pop();
  endtask

  task automatic test_random();
    logic [7:0] pool [12];
    logic [7:0] b;
    logic err, rd;
    int g;
    pool = '{8'h12, 8'h14, 8'h11, 8'h58, 8'h1C, 8'h75, 8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h00, 8'hFA};
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 0) hard_reset();
      g = int'($urandom_range(0, 15));
      b = (g < 12) ? pool[g] : 8'($urandom_range(0, 255));
      if (b == 8'h59) b = 8'h12;
      err = ($urandom_range(0, 19) == 0);
      rd  = ($urandom_range(0, 2) == 0);
      g = int'($urandom_range(0, 30));
      if (g == 0) idle(TO + 2);
      else if (g < 6) idle(1);
      if ($urandom_range(0, 3) == 0) do_pop();
      send(b, err, rd);
      checks++; if (evt_valid !== (q.size() != 0)) begin errs++; $display("FAIL rnd_valid@%0d: got %b want %b", n, evt_valid, q.size() != 0); end
      if (q.size() > 0) begin
        checks++; if (evt_data !== q[0]) begin errs++; $display("FAIL rnd_data@%0d: got %h want %h", n, evt_data, q[0]); end
      end
      checks++; if (mods !== m_mods) begin errs++; $display("FAIL rnd_mods@%0d: got %b want %b", n, mods, m_mods); end
      checks++; if (caps !== m_caps) begin errs++; $display("FAIL rnd_caps@%0d: got %b want %b", n, caps, m_caps); end
      checks++; if (ovf !== m_ovf) begin errs++; $display("FAIL rnd_ovf@%0d: got %b want %b", n, ovf, m_ovf); end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    m_clear();
    test_reset();
    test_make_break();
    test_ext();
    test_pause();
    test_mods();
    test_overflow();
    test_timeout_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
